// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types for the data-memory responder: the LC-3b word type used for
// addresses and data, the responder FSM state encoding and the width of the
// latency counter.
// Build option: DMEM_ALIGN_CHECK_EN (consumed by dmem_responder.sv).
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Counter holds LATENCY-2 at most; LATENCY tops out at 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Requester <-> responder bus.
//   master : drives mem_read, mem_write, mem_byte_enable, mem_address,
//            mem_wdata; samples mem_rdata, mem_resp, mem_busy, mem_error.
//   slave  : the mirror image.
//
// Handshake: the requester raises mem_read and/or mem_write together with
// address, byte enables and write data, and holds them until it sees
// mem_resp=1. The responder accepts only while idle, completes with a single
// mem_resp pulse, and rdata/error are meaningful only during that pulse.
// A request still held after the pulse is taken as a new transaction.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  lc3b_word   mem_address;
  lc3b_word   mem_wdata;
  lc3b_word   mem_rdata;
  logic       mem_resp;
  logic       mem_busy;
  logic       mem_error;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_busy, mem_error
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_busy, mem_error
  );

endinterface

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// 2^DEPTH_LOG2 x 16-bit storage split into two byte lanes.
//   clk   : write clock
//   we    : write strobe (committed on the rising edge)
//   be    : byte lane enables, bit0 = low byte, bit1 = high byte
//   idx   : word index, shared by read and write
//   wdata : write data
//   rdata : combinational read of word idx
// Contents are never cleared.
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  lc3b_word              wdata,
  output lc3b_word              rdata
);

  logic [7:0] mem_lo [2**DEPTH_LOG2];
  logic [7:0] mem_hi [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we && be[0]) mem_lo[idx] <= wdata[7:0];
    if (we && be[1]) mem_hi[idx] <= wdata[15:8];
  end

  assign rdata = {mem_hi[idx], mem_lo[idx]};

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Fixed-latency data-memory model for an LC-3b style requester.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset (storage contents survive it)
//   bus   : dmem_responder_if.slave request/response bus
//   state : current FSM state, for observation
// Parameters: LATENCY (1..15) edges from acceptance to the response cycle,
// DEPTH_LOG2 word-address bits.
// Build option DMEM_ALIGN_CHECK_EN: word access to an odd address, or read
// and write raised together, completes with mem_error=1 and no side effect.
// Without it address[0] is ignored and write wins over read.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_responder_if.slave bus,
  output dmem_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  logic [CNT_W-1:0]      cnt;
  logic                  op_write_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  lc3b_word              wdata_q;
  logic [1:0]            be_q;

  logic                  resp_q;
  logic                  busy_q;
  logic                  error_q;
  lc3b_word              rdata_q;

  logic                  req;
  logic                  bad_req;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_idx;
  lc3b_word              arr_rdata;
  lc3b_word              rsp_data;
  logic                  unused_addr;

  assign req = bus.mem_read | bus.mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad_req = ((bus.mem_byte_enable == 2'b11) && bus.mem_address[0]) ||
                   (bus.mem_read && bus.mem_write);
`else
  assign bad_req = 1'b0;
`endif

  assign unused_addr = ^{bus.mem_address[15:DEPTH_LOG2+1], bus.mem_address[0]};

  // While idle the array looks at the live address so a LATENCY=1 read can
  // load its response on the acceptance edge; afterwards the captured index.
  assign arr_idx = (state == IDLE) ? bus.mem_address[DEPTH_LOG2:1] : idx_q;

  // Writes land on the edge that ends RESP; a reset on that edge cancels it.
  assign arr_we = rst_n && (state == RESP) && op_write_q && !err_q;

  always_comb begin
    rsp_data = arr_rdata;
    if (state == IDLE) begin
      if (bus.mem_write || bad_req) rsp_data = '0;
    end else begin
      if (op_write_q || err_q) rsp_data = '0;
    end
  end

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (be_q),
    .idx   (arr_idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_write_q <= bus.mem_write;
            err_q      <= bad_req;
            idx_q      <= bus.mem_address[DEPTH_LOG2:1];
            wdata_q    <= bus.mem_wdata;
            be_q       <= bus.mem_byte_enable;
            busy_q     <= 1'b1;
            if (LATENCY == 1) begin
              state   <= RESP;
              resp_q  <= 1'b1;
              error_q <= bad_req;
              rdata_q <= rsp_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            resp_q  <= 1'b1;
            error_q <= err_q;
            rdata_q <= rsp_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          resp_q  <= 1'b0;
          busy_q  <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state  <= IDLE;
          resp_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_busy  = busy_q;
  assign bus.mem_error = error_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Drives a LATENCY=2 instance through directed and random transactions and a
// LATENCY=1 instance through back-to-back held requests. Expected read data,
// error flags and latencies come from a word-level memory model.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LAT = 2;
  localparam int DL2 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus0();
  dmem_responder_if bus1();
  dmem_state_t state0;
  dmem_state_t state1;

  dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0),
    .state (state0)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_LOG2(DL2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .state (state1)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_mem [int];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % (1 << DL2);
  endfunction

  function automatic bit is_bad(input bit wr, input bit rd, input logic [1:0] be,
                                input logic [15:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return ((be == 2'b11) && a[0]) || (wr && rd);
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour of one completed transaction.
  task automatic model_apply(input bit wr, input bit rd, input logic [1:0] be,
                             input logic [15:0] a, input logic [15:0] wd,
                             output logic [15:0] exp_rdata, output logic exp_err);
    int w;
    logic [15:0] word;
    w = widx(a);
    exp_err = is_bad(wr, rd, be, a);
    exp_rdata = 16'h0000;
    if (!exp_err) begin
      if (wr) begin
        word = model_mem.exists(w) ? model_mem[w] : 16'h0000;
        if (be[0]) word[7:0]  = wd[7:0];
        if (be[1]) word[15:8] = wd[15:8];
        if (be != 2'b00) model_mem[w] = word;
      end else begin
        exp_rdata = model_mem[w];
      end
    end
  endtask

  // ---------------- driver ----------------
  // Starts and ends at a negedge with the DUT idle.
  task automatic do_txn(input bit wr, input bit rd, input logic [1:0] be,
                        input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rdata, output logic err,
                        output int lat, output bit busy_ok);
    bus0.mem_write       = wr;
    bus0.mem_read        = rd;
    bus0.mem_byte_enable = be;
    bus0.mem_address     = a;
    bus0.mem_wdata       = wd;
    @(posedge clk);
    lat = 1;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.mem_busy !== 1'b1) busy_ok = 1'b0;
      if (bus0.mem_resp === 1'b1) break;
      lat++;
    end
    rdata = bus0.mem_rdata;
    err   = bus0.mem_error;
    bus0.mem_write = 1'b0;
    bus0.mem_read  = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input bit wr, input bit rd,
                         input logic [1:0] be, input logic [15:0] a,
                         input logic [15:0] wd);
    logic [15:0] exp_rdata;
    logic exp_err;
    logic [15:0] rdata;
    logic err;
    int lat;
    bit busy_ok;
    model_apply(wr, rd, be, a, wd, exp_rdata, exp_err);
    exp_q.push_back(exp_rdata);
    do_txn(wr, rd, be, a, wd, rdata, err, lat, busy_ok);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_rdata"}, 32'(rdata), 32'(exp_q.pop_front()));
    check({tag, "_error"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_idle_after"}, {29'd0, bus0.mem_resp, bus0.mem_busy, 1'b0},
          {29'd0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic count_resp(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus0.mem_resp === 1'b1) pulses++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int pulses;
    bit wr;
    bit rd;
    logic [1:0] be;
    logic [15:0] a;

    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.mem_byte_enable = 2'b00;
    bus0.mem_address = 16'h0000; bus0.mem_wdata = 16'h0000;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_byte_enable = 2'b00;
    bus1.mem_address = 16'h0000; bus1.mem_wdata = 16'h0000;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state0), 32'(IDLE));
    check("rst_resp", 32'(bus0.mem_resp), 32'd0);
    check("rst_busy", 32'(bus0.mem_busy), 32'd0);
    check("rst_error", 32'(bus0.mem_error), 32'd0);
    check("rst_rdata", 32'(bus0.mem_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read, LATENCY cycles each
    run_txn("wr_1234", 1, 0, 2'b11, 16'h0010, 16'h1234);
    run_txn("rd_1234", 0, 1, 2'b11, 16'h0010, 16'h0000);
    check("rd_1234_const", 32'(model_mem[widx(16'h0010)]), 32'h1234);

    // Byte-lane merging
    run_txn("wr_aaaa", 1, 0, 2'b11, 16'h0020, 16'hAAAA);
    run_txn("wr_lo55", 1, 0, 2'b01, 16'h0020, 16'h0055);
    run_txn("rd_aa55", 0, 1, 2'b11, 16'h0020, 16'h0000);
    run_txn("wr_hi77", 1, 0, 2'b10, 16'h0020, 16'h7700);
    run_txn("rd_7755", 0, 1, 2'b11, 16'h0020, 16'h0000);
    run_txn("wr_be00", 1, 0, 2'b00, 16'h0020, 16'hFFFF);
    run_txn("rd_be00", 0, 1, 2'b11, 16'h0020, 16'h0000);

    // Read dropped during WAIT still completes once
    bus0.mem_read = 1'b1; bus0.mem_byte_enable = 2'b11; bus0.mem_address = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    check("drop_in_wait_state", 32'(state0), 32'(WAIT));
    bus0.mem_read = 1'b0;
    @(negedge clk);
    check("drop_resp", 32'(bus0.mem_resp), 32'd1);
    check("drop_rdata", 32'(bus0.mem_rdata), 32'(model_mem[widx(16'h0010)]));
    count_resp(8, pulses);
    check("drop_no_second", 32'(pulses), 32'd0);

    // Reset during WAIT aborts the write
    run_txn("wr_5a5a", 1, 0, 2'b11, 16'h0030, 16'h5A5A);
    bus0.mem_write = 1'b1; bus0.mem_byte_enable = 2'b11;
    bus0.mem_address = 16'h0030; bus0.mem_wdata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus0.mem_write = 1'b0;
    @(negedge clk);
    check("rst_wait_state", 32'(state0), 32'(IDLE));
    check("rst_wait_resp", 32'(bus0.mem_resp), 32'd0);
    check("rst_wait_busy", 32'(bus0.mem_busy), 32'd0);
    rst_n = 1'b1;
    count_resp(6, pulses);
    check("rst_wait_no_resp", 32'(pulses), 32'd0);
    run_txn("rd_5a5a", 0, 1, 2'b11, 16'h0030, 16'h0000);

    // Reset on the edge ending RESP also drops the write
    run_txn("wr_0c0c", 1, 0, 2'b11, 16'h0032, 16'h0C0C);
    bus0.mem_write = 1'b1; bus0.mem_byte_enable = 2'b11;
    bus0.mem_address = 16'h0032; bus0.mem_wdata = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_in_resp", 32'(bus0.mem_resp), 32'd1);
    rst_n = 1'b0;
    bus0.mem_write = 1'b0;
    @(negedge clk);
    check("rst_resp_state", 32'(state0), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    run_txn("rd_0c0c", 0, 1, 2'b11, 16'h0032, 16'h0000);

    // Odd-address word write, read+write together, aliasing
    run_txn("wr_odd", 1, 0, 2'b11, 16'h0031, 16'h1357);
    run_txn("rd_odd", 0, 1, 2'b11, 16'h0030, 16'h0000);
    run_txn("wr_rdwr", 1, 1, 2'b11, 16'h0040, 16'h2468);
    run_txn("rd_rdwr", 0, 1, 2'b11, 16'h0040, 16'h0000);
    run_txn("wr_alias", 1, 0, 2'b11, 16'h0242, 16'h9ABC);
    run_txn("rd_alias", 0, 1, 2'b11, 16'h0042, 16'h0000);

    // Random traffic over a small known region
    for (int k = 0; k < 8; k++)
      run_txn("fill", 1, 0, 2'b11, 16'(16'h0100 + 2 * k), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      be = 2'($urandom_range(0, 3));
      a  = 16'(16'h0100 + 2 * $urandom_range(0, 7) + $urandom_range(0, 1)
               + ($urandom_range(0, 3) << 9));
      run_txn("rand", wr, rd, be, a, 16'($urandom));
    end

    // LATENCY=1: held write, then held read; response every second cycle
    bus1.mem_write = 1'b1; bus1.mem_byte_enable = 2'b11;
    bus1.mem_address = 16'h0004; bus1.mem_wdata = 16'h1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("l1_wr_resp", 32'(bus1.mem_resp), 32'(k % 2 == 0));
      check("l1_wr_busy", 32'(bus1.mem_busy), 32'(k % 2 == 0));
      if (k == 4) bus1.mem_write = 1'b0;
    end
    bus1.mem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("l1_rd_resp", 32'(bus1.mem_resp), 32'(k % 2 == 0));
      check("l1_rd_busy", 32'(bus1.mem_busy), 32'(k % 2 == 0));
      check("l1_rd_data", 32'(bus1.mem_rdata), (k % 2 == 0) ? 32'h1111 : 32'h0);
      if (k == 2) bus1.mem_read = 1'b0;
    end
    @(negedge clk);
    check("l1_idle_state", 32'(state1), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, legal 1..15: cycles from request acceptance to mem_resp.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: storage of 2^DEPTH_LOG2 16-bit words.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port mem_read, input, 1: read request, held by the requester until mem_resp.
REQ-006 SHALL have port mem_write, input, 1: write request, held by the requester until mem_resp.
REQ-007 SHALL have port mem_byte_enable, input, 2: bit0 = low byte, bit1 = high byte of the word.
REQ-008 SHALL have port mem_address, input, 16 (lc3b_word): byte address.
REQ-009 SHALL have port mem_wdata, input, 16: write data.
REQ-010 SHALL have port mem_rdata, output, 16: read data, valid only while mem_resp=1.
REQ-011 SHALL have port mem_resp, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port mem_busy, output, 1: high in WAIT and RESP.
REQ-013 SHALL have port mem_error, output, 1: error qualifier, valid with mem_resp.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; LATENCY=1 goes IDLE -> RESP directly.
REQ-015 In IDLE, with mem_read or mem_write high at the edge: SHALL capture op, address, wdata, byte_enable; load counter with LATENCY-2 and enter WAIT (LATENCY>=2).
REQ-016 WAIT SHALL decrement the counter each cycle and enter RESP in the cycle after the counter reaches 0; mem_resp therefore asserts exactly LATENCY cycles after the acceptance edge.
REQ-017 RESP SHALL last exactly one cycle with mem_resp=1, then return to IDLE.
REQ-018 Word index SHALL be captured address[DEPTH_LOG2:1]; upper address bits ignored (aliasing wraps).
REQ-019 A write SHALL update only the bytes whose enable bit is 1, committed at the edge ending RESP; byte_enable 2'b00 writes nothing but still responds.
REQ-020 A read SHALL drive mem_rdata with the full 16-bit word (byte steering is the requester's job); mem_rdata SHALL be 0 outside RESP.
REQ-021 With mem_read and mem_write both high, write SHALL take precedence.
REQ-022 Inputs SHALL be ignored outside IDLE; dropping a request during WAIT SHALL NOT cancel the captured transaction.
REQ-023 A request still high in the IDLE cycle after RESP SHALL be accepted as a new transaction.
REQ-024 A read following a write to the same word SHALL return the new data.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, counter 0, mem_resp 0, mem_busy 0, mem_error 0, mem_rdata 0, from any state.
REQ-026 Reset during WAIT or RESP SHALL abort with no array update.
REQ-027 Storage array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: byte_enable 2'b11 with address[0]=1, or read and write both high, SHALL complete with mem_resp=1, mem_error=1, mem_rdata=0 and no array update.
REQ-029 DMEM_ALIGN_CHECK_EN undefined: address[0] ignored for word accesses, REQ-021 applies, mem_error tied 0.

Structure
REQ-030 lc3b_types SHALL gain dmem_state_t (IDLE, WAIT, RESP); lc3b_word reused for address/data.
REQ-031 Storage SHALL be sub-module dmem_array: synchronous byte-enabled write, combinational read.

Verification
REQ-032 LATENCY=2: write 0x1234 to 0x0010 be=11 -> mem_resp exactly 2 cycles after accept; read 0x0010 -> rdata 0x1234.
REQ-033 Word 0x0020=0xAAAA; write 0x0055 be=01 -> read gives 0xAA55; write 0x7700 be=10 -> 0x7755.
REQ-034 Read request dropped during WAIT -> mem_resp still one pulse; no second transaction.
REQ-035 rst_n low during WAIT of write 0xBEEF to 0x0030 -> IDLE, no mem_resp, word 0x0030 unchanged.
REQ-036 DMEM_ALIGN_CHECK_EN: word write to 0x0031 -> mem_resp=1, mem_error=1, array unchanged; without macro -> word 0x0030 written.
REQ-037 LATENCY=1 with back-to-back held requests -> resp on every second cycle; mem_busy correct throughout.
